// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES carry-rippled chunks,
// one chunk per rank, with a global-stall valid/ready pipeline and carry/overflow/zero flags.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    // Rank registers: operands travel along, result chunks fill in from the LSB upward.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q, zero_q;

    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];
    logic             c_in [STAGES];
    logic             c_nx [STAGES];
    logic             v_in [STAGES];
    logic [CHUNK:0]   sum;
    logic             adv, ovf_d, zero_d;

    assign adv      = !v_q[LAST] || out_ready;
    assign in_ready = adv;

    always_comb begin
        a_in[0] = A;
        b_in[0] = Sub ? ~B : B;
        s_in[0] = '0;
        c_in[0] = Cin ^ Sub;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
        sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            sum = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, c_in[k]};
            s_nx[k] = s_in[k];
            s_nx[k][k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            c_nx[k] = sum[CHUNK];
        end
        // Carry into the MSB is recovered as a ^ b ^ s at that bit.
        ovf_d  = v_in[LAST] & (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1]
                             ^ s_nx[LAST][WIDTH-1] ^ c_nx[LAST]);
        zero_d = v_in[LAST] & (s_nx[LAST] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
                c_q[k] <= c_nx[k];
                v_q[k] <= v_in[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign S         = s_q[LAST];
    assign Cout      = c_q[LAST];
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 8-bit instances with 4, 1 and 8 ranks sharing one stimulus.
module tb_pipelined_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, Cin, Sub;
    logic [7:0] A, B;
    logic       in_ready, out_valid, Cout, Ovf, Zero;
    logic [7:0] S;
    logic       in_ready1, out_valid1, Cout1, Ovf1, Zero1;
    logic [7:0] S1;
    logic       in_ready8, out_valid8, Cout8, Ovf8, Zero8;
    logic [7:0] S8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready), .S(S),
        .Cout(Cout), .Ovf(Ovf), .Zero(Zero)
    );
    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .A(A), .B(B),
        .Cin(Cin), .Sub(Sub), .out_valid(out_valid1), .out_ready(1'b1), .S(S1),
        .Cout(Cout1), .Ovf(Ovf1), .Zero(Zero1)
    );
    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .A(A), .B(B),
        .Cin(Cin), .Sub(Sub), .out_valid(out_valid8), .out_ready(1'b1), .S(S8),
        .Cout(Cout8), .Ovf(Ovf8), .Zero(Zero8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {ovf, zero, cout, s}; overflow from sign rules.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic sub);
        logic [8:0] r;
        logic [7:0] s;
        logic       c, o;
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            s = r[7:0];
            c = r[8];
            o = (a[7] == b[7]) && (s[7] != a[7]);
        end else begin
            s = a - b - {7'b0, cin};
            c = ({1'b0, a} >= ({1'b0, b} + {8'b0, cin}));
            o = (a[7] != b[7]) && (s[7] != a[7]);
        end
        return {o, (s == 8'h00), c, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub, input logic [7:0] es,
                           input logic ec, input logic eo, input logic ez);
        int n;
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " result"}, 32'({Ovf, Zero, Cout, S}), 32'({eo, ez, ec, es}));
        tick();
        check({tag, " retired"}, 32'(out_valid), 32'd0);
    endtask

    task automatic cmp_out(input string tag, input int idx, input logic [10:0] exp,
                           input logic v, input logic [7:0] s, input logic c,
                           input logic o, input logic z);
        if (idx >= 0 && idx < 16) begin
            check({tag, " valid"}, 32'(v), 32'd1);
            check({tag, " data"}, 32'({o, z, c, s}), 32'(exp));
        end else begin
            check({tag, " idle"}, 32'(v), 32'd0);
        end
    endtask

    logic [7:0]  sa [16];
    logic [7:0]  sb [16];
    logic        sc [16];
    logic        ss [16];
    logic [10:0] sexp [16];
    logic [10:0] q [$];
    logic [10:0] head;
    logic [7:0]  held;
    logic        prev_stall;
    int          j, got, stray;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        tick();
        tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst outputs", 32'({Ovf, Zero, Cout, S}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        run_one("add ff+01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_one("add 7f+01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_one("add 3f+00+c",  8'h3F, 8'h00, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0);
        run_one("sub 05-07",    8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_one("sub 80-01",    8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_one("sub 10-0f-b",  8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_one("add ff+00+c",  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Backpressure: three stalled cycles in the middle of an 8-op stream.
        j = 0; got = 0; prev_stall = 1'b0; held = '0;
        for (int i = 0; i < 16; i++) begin
            sa[i] = 8'($urandom); sb[i] = 8'($urandom);
            sc[i] = 1'($urandom); ss[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 8);
            if (j < 8) begin
                A = sa[j]; B = sb[j]; Cin = sc[j]; Sub = ss[j]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                check("bp in_ready", 32'(in_ready), 32'd0);
                if (prev_stall) check("bp hold", 32'(S), 32'(held));
                held = S;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                head = (q.size() > 0) ? q.pop_front() : 11'h7FF;
                check("bp order", 32'({Ovf, Zero, Cout, S}), 32'(head));
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(sa[j], sb[j], sc[j], ss[j]));
                j++;
            end
            tick();
        end
        check("bp count", 32'(got), 32'd8);
        check("bp drained", 32'(q.size()), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();
        check("bp no dup", 32'(out_valid), 32'd0);

        // Back-to-back stream through the 4-, 1- and 8-rank instances.
        for (int i = 0; i < 16; i++) begin
            sa[i] = 8'($urandom); sb[i] = 8'($urandom);
            sc[i] = 1'($urandom); ss[i] = 1'($urandom);
            sexp[i] = model(sa[i], sb[i], sc[i], ss[i]);
        end
        for (int e = 0; e < 24; e++) begin
            if (e < 16) begin
                A = sa[e]; B = sb[e]; Cin = sc[e]; Sub = ss[e]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cmp_out("s4", e - 3, sexp[(e >= 3 && e < 19) ? e - 3 : 0],
                    out_valid, S, Cout, Ovf, Zero);
            cmp_out("s1", e, sexp[(e < 16) ? e : 0], out_valid1, S1, Cout1, Ovf1, Zero1);
            cmp_out("s8", e - 7, sexp[(e >= 7 && e < 23) ? e - 7 : 0],
                    out_valid8, S8, Cout8, Ovf8, Zero8);
            check("s1 in_ready", 32'(in_ready1), 32'd1);
            check("s8 in_ready", 32'(in_ready8), 32'd1);
        end

        // Reset with one result presented and three operations in flight.
        for (int i = 0; i < 4; i++) begin
            A = (i == 0) ? 8'hFF : 8'h11; B = 8'h01; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("pre-rst head", 32'({out_valid, Zero, Cout}), 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-rst out_valid", 32'(out_valid), 32'd0);
        check("mid-rst outputs", 32'({Ovf, Zero, Cout, S}), 32'd0);
        check("mid-rst in_ready", 32'(in_ready), 32'd1);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) stray++;
        end
        check("no stale results", 32'(stray), 32'd0);
        run_one("post-rst sub", 8'h20, 8'h21, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
